// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: places a food cell on the snake grid from PRNG draws,
// retrying on out-of-range or occupied cells, then falling back to a scan.
module food_spawn_ctrl #(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 15,
    parameter int MAX_TRIES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_req,
    input  logic [4:0] prng_num,
    output logic       prng_load,
    output logic       occ_query,
    output logic [4:0] occ_x,
    output logic [4:0] occ_y,
    input  logic       occ_valid,
    input  logic       occ_hit,
    output logic [4:0] food_x,
    output logic [4:0] food_y,
    output logic       food_valid,
    output logic       grid_full,
    output logic       busy
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    // Six-bit limits so a 32-wide grid still compares correctly.
    localparam logic [5:0]    W_LIM   = 6'(GRID_W);
    localparam logic [5:0]    H_LIM   = 6'(GRID_H);
    localparam logic [4:0]    X_MAX   = 5'(GRID_W - 1);
    localparam logic [4:0]    Y_MAX   = 5'(GRID_H - 1);
    localparam logic [TW-1:0] TRY_MAX = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        SEED,
        IDLE,
        SAMPLE_X,
        SAMPLE_Y,
        QUERY,
        SCAN
    } state_t;

    state_t        state;
    logic [4:0]    cand_x;
    logic [4:0]    cand_y;
    logic [TW-1:0] tries;
    logic [TW-1:0] tries_inc;
    logic          x_ok;
    logic          y_ok;
    logic          tries_done;
    logic          scan_last;
    logic [4:0]    scan_nx;
    logic [4:0]    scan_ny;

    // Seed strobe and busy flag decode straight from the state register.
    assign prng_load = (state == SEED);
    assign busy      = (state == SAMPLE_X) || (state == SAMPLE_Y) ||
                       (state == QUERY)    || (state == SCAN);

    // Range checks, try bookkeeping and row-major successor of the scan cell.
    always_comb begin
        x_ok       = ({1'b0, prng_num} < W_LIM);
        y_ok       = ({1'b0, prng_num} < H_LIM);
        tries_inc  = tries + TW'(1);
        tries_done = (tries_inc == TRY_MAX);
        scan_last  = (cand_x == X_MAX) && (cand_y == Y_MAX);
        scan_nx    = cand_x + 5'd1;
        scan_ny    = cand_y;
        if (cand_x == X_MAX) begin
            scan_nx = 5'd0;
            scan_ny = cand_y + 5'd1;
        end
    end

    // Main sequencer: sampling, occupancy handshake, fallback scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEED;
            cand_x     <= 5'd0;
            cand_y     <= 5'd0;
            tries      <= '0;
            occ_query  <= 1'b0;
            occ_x      <= 5'd0;
            occ_y      <= 5'd0;
            food_x     <= 5'd0;
            food_y     <= 5'd0;
            food_valid <= 1'b0;
            grid_full  <= 1'b0;
        end else begin
            unique case (state)
                SEED: begin
                    state <= IDLE;
                end
                IDLE: begin
                    if (spawn_req) begin
                        food_valid <= 1'b0;
                        grid_full  <= 1'b0;
                        tries      <= '0;
                        state      <= SAMPLE_X;
                    end
                end
                SAMPLE_X: begin
                    if (x_ok) begin
                        cand_x <= prng_num;
                        state  <= SAMPLE_Y;
                    end else begin
                        tries <= tries_inc;
                        if (tries_done) begin
                            cand_x    <= 5'd0;
                            cand_y    <= 5'd0;
                            occ_x     <= 5'd0;
                            occ_y     <= 5'd0;
                            occ_query <= 1'b1;
                            state     <= SCAN;
                        end
                    end
                end
                SAMPLE_Y: begin
                    if (y_ok) begin
                        cand_y    <= prng_num;
                        occ_x     <= cand_x;
                        occ_y     <= prng_num;
                        occ_query <= 1'b1;
                        state     <= QUERY;
                    end else begin
                        tries <= tries_inc;
                        if (tries_done) begin
                            cand_x    <= 5'd0;
                            cand_y    <= 5'd0;
                            occ_x     <= 5'd0;
                            occ_y     <= 5'd0;
                            occ_query <= 1'b1;
                            state     <= SCAN;
                        end
                    end
                end
                QUERY: begin
                    if (occ_valid) begin
                        if (!occ_hit) begin
                            occ_query  <= 1'b0;
                            food_x     <= cand_x;
                            food_y     <= cand_y;
                            food_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            tries <= tries_inc;
                            if (tries_done) begin
                                cand_x <= 5'd0;
                                cand_y <= 5'd0;
                                occ_x  <= 5'd0;
                                occ_y  <= 5'd0;
                                state  <= SCAN;
                            end else begin
                                occ_query <= 1'b0;
                                state     <= SAMPLE_X;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (occ_valid) begin
                        if (!occ_hit) begin
                            occ_query  <= 1'b0;
                            food_x     <= cand_x;
                            food_y     <= cand_y;
                            food_valid <= 1'b1;
                            state      <= IDLE;
                        end else if (scan_last) begin
                            occ_query  <= 1'b0;
                            grid_full  <= 1'b1;
                            food_valid <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            cand_x <= scan_nx;
                            cand_y <= scan_ny;
                            occ_x  <= scan_nx;
                            occ_y  <= scan_ny;
                        end
                    end
                end
                default: begin
                    state <= SEED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb_food_spawn_ctrl: directed and randomized checks of food_spawn_ctrl
// against a behavioural placement model.
module tb_food_spawn_ctrl;

    localparam int GW = 20;
    localparam int GH = 15;
    localparam int MT = 15;

    logic       clk;
    logic       rst;
    logic       spawn_req;
    logic [4:0] prng_num;
    logic       prng_load;
    logic       occ_query;
    logic [4:0] occ_x;
    logic [4:0] occ_y;
    logic       occ_valid;
    logic       occ_hit;
    logic [4:0] food_x;
    logic [4:0] food_y;
    logic       food_valid;
    logic       grid_full;
    logic       busy;

    logic       s_spawn;
    logic [4:0] s_prng;
    logic       s_prng_load;
    logic       s_occ_query;
    logic [4:0] s_occ_x;
    logic [4:0] s_occ_y;
    logic       s_occ_valid;
    logic       s_occ_hit;
    logic [4:0] s_food_x;
    logic [4:0] s_food_y;
    logic       s_food_valid;
    logic       s_grid_full;
    logic       s_busy;

    int checks;
    int failures;
    int lat;
    int rcnt;
    int stream [128];
    bit occ [32][32];
    int last_qx;
    int last_qy;

    food_spawn_ctrl #(.GRID_W(GW), .GRID_H(GH), .MAX_TRIES(MT)) dut (
        .clk       (clk),
        .rst       (rst),
        .spawn_req (spawn_req),
        .prng_num  (prng_num),
        .prng_load (prng_load),
        .occ_query (occ_query),
        .occ_x     (occ_x),
        .occ_y     (occ_y),
        .occ_valid (occ_valid),
        .occ_hit   (occ_hit),
        .food_x    (food_x),
        .food_y    (food_y),
        .food_valid(food_valid),
        .grid_full (grid_full),
        .busy      (busy)
    );

    food_spawn_ctrl #(.GRID_W(4), .GRID_H(2), .MAX_TRIES(2)) sdut (
        .clk       (clk),
        .rst       (rst),
        .spawn_req (s_spawn),
        .prng_num  (s_prng),
        .prng_load (s_prng_load),
        .occ_query (s_occ_query),
        .occ_x     (s_occ_x),
        .occ_y     (s_occ_y),
        .occ_valid (s_occ_valid),
        .occ_hit   (s_occ_hit),
        .food_x    (s_food_x),
        .food_y    (s_food_y),
        .food_valid(s_food_valid),
        .grid_full (s_grid_full),
        .busy      (s_busy)
    );

    assign s_occ_valid = s_occ_query;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy responder: answers after lat wait cycles, per lookup.
    always @(posedge clk) begin
        if (rst || !occ_query || occ_valid) rcnt <= 0;
        else rcnt <= rcnt + 1;
    end

    always @(negedge clk) begin
        occ_valid = occ_query && (rcnt == lat);
        occ_hit   = occ_query ? occ[occ_y][occ_x] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected placement: walk the PRNG stream one value per cycle,
    // count rejections, then fall back to the first free cell row-major.
    function automatic void model(input int lt, output int ex, output int ey,
                                  output bit ef, output int ee);
        int pos;
        int tries;
        int cx;
        int cy;
        int v;
        bit want_y;
        pos = 0; tries = 0; cx = 0; cy = 0; want_y = 0;
        ex = 0; ey = 0; ef = 0; ee = 0;
        while (tries < MT) begin
            v = stream[pos];
            pos++;
            if (!want_y) begin
                if (v < GW) begin
                    cx = v;
                    want_y = 1;
                end else tries++;
            end else if (v < GH) begin
                cy = v;
                pos += lt + 1;
                if (!occ[cy][cx]) begin
                    ex = cx; ey = cy; ee = pos;
                    return;
                end
                tries++;
                want_y = 0;
            end else tries++;
        end
        for (int i = 0; i < GW * GH; i++) begin
            pos += lt + 1;
            if (!occ[i / GW][i % GW]) begin
                ex = i % GW; ey = i / GW; ee = pos;
                return;
            end
        end
        ef = 1;
        ee = pos;
    endfunction

    task automatic clear_occ();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                occ[y][x] = 1'b0;
    endtask

    task automatic rand_stream();
        for (int i = 0; i < 128; i++) stream[i] = int'($urandom_range(0, 31));
    endtask

    // Issue one request and count edges from the sampling edge to done.
    task automatic run_spawn(output int edges);
        @(negedge clk);
        spawn_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        spawn_req = 1'b0;
        edges = 0;
        while (!(food_valid || grid_full) && edges < 3000) begin
            prng_num = 5'(edges < 128 ? stream[edges] : 31);
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (occ_query) begin
                last_qx = int'(occ_x);
                last_qy = int'(occ_y);
            end
        end
    endtask

    task automatic spawn_and_check(input string tag);
        int ex;
        int ey;
        bit ef;
        int ee;
        int edges;
        model(lat, ex, ey, ef, ee);
        run_spawn(edges);
        check({tag, "_edges"}, edges, ee);
        check({tag, "_full"}, grid_full, ef);
        check({tag, "_valid"}, food_valid, !ef);
        if (!ef) begin
            check({tag, "_x"}, food_x, ex);
            check({tag, "_y"}, food_y, ey);
        end
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int edges;
        int idx;
        int dens;
        checks = 0; failures = 0; lat = 0;
        rst = 1'b1; spawn_req = 1'b0; prng_num = 5'd0;
        s_spawn = 1'b0; s_prng = 5'd31; s_occ_hit = 1'b1;
        last_qx = -1; last_qy = -1;
        clear_occ();
        repeat (3) @(posedge clk);

        // Reset release: one-cycle seed strobe, quiet outputs.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("seed_load_hi", prng_load, 1);
        check("rst_busy", busy, 0);
        check("rst_food_valid", food_valid, 0);
        check("rst_grid_full", grid_full, 0);
        check("rst_occ_query", occ_query, 0);
        @(posedge clk);
        #1;
        check("seed_load_lo", prng_load, 0);
        check("seed_load_lo_s", s_prng_load, 0);

        // Best case: draws 3 then 7, free cell, zero-wait lookup.
        rand_stream();
        stream[0] = 3; stream[1] = 7;
        run_spawn(edges);
        check("best_edges", edges, 3);
        check("best_qx", last_qx, 3);
        check("best_qy", last_qy, 7);
        check("best_fx", food_x, 3);
        check("best_fy", food_y, 7);
        check("best_valid", food_valid, 1);

        // Range rejections: 25, 30 for x, 20 for y.
        rand_stream();
        stream[0] = 25; stream[1] = 30; stream[2] = 4;
        stream[3] = 20; stream[4] = 2;
        run_spawn(edges);
        check("rej_edges", edges, 6);
        check("rej_fx", food_x, 4);
        check("rej_fy", food_y, 2);

        // Slow lookup: query held stable; spawn pulses while busy ignored.
        lat = 5;
        @(negedge clk); spawn_req = 1'b1;
        @(posedge clk);
        @(negedge clk); spawn_req = 1'b0; prng_num = 5'd3;
        @(posedge clk);
        @(negedge clk); prng_num = 5'd7;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("slow_query", occ_query, 1);
            check("slow_qx", occ_x, 3);
            check("slow_qy", occ_y, 7);
            spawn_req = (k < 5);
            @(posedge clk);
        end
        @(negedge clk);
        check("slow_valid", food_valid, 1);
        check("slow_fx", food_x, 3);
        check("slow_fy", food_y, 7);
        check("slow_drop", occ_query, 0);
        @(posedge clk);
        #1;
        check("slow_ignored", busy, 0);
        check("slow_keep", food_valid, 1);
        lat = 0;

        // Small grid, always occupied: full row-major scan then grid_full.
        @(negedge clk); s_spawn = 1'b1;
        @(posedge clk);
        @(negedge clk); s_spawn = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && !s_grid_full; c++) begin
            @(negedge clk);
            if (s_occ_query) begin
                check("scan_x", s_occ_x, idx % 4);
                check("scan_y", s_occ_y, idx / 4);
                idx++;
            end
        end
        check("scan_count", idx, 8);
        check("scan_full", s_grid_full, 1);
        check("scan_valid", s_food_valid, 0);
        check("scan_busy", s_busy, 0);

        // Randomized requests against the placement model.
        for (int t = 0; t < 24; t++) begin
            lat = int'($urandom_range(0, 2));
            dens = int'($urandom_range(0, 3));
            rand_stream();
            for (int y = 0; y < GH; y++)
                for (int x = 0; x < GW; x++)
                    case (dens)
                        0: occ[y][x] = 1'b0;
                        1: occ[y][x] = ($urandom_range(0, 99) < 50);
                        2: occ[y][x] = ($urandom_range(0, 99) < 97);
                        default: occ[y][x] = 1'b1;
                    endcase
            spawn_and_check("rand");
        end

        // Reset during a lookup aborts it and re-seeds.
        clear_occ();
        lat = 10;
        @(negedge clk); spawn_req = 1'b1;
        @(posedge clk);
        @(negedge clk); spawn_req = 1'b0; prng_num = 5'd3;
        @(posedge clk);
        @(negedge clk); prng_num = 5'd7;
        @(posedge clk);
        @(negedge clk);
        check("abort_pre", occ_query, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_query", occ_query, 0);
        check("abort_load", prng_load, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reseed_hi", prng_load, 1);
        @(posedge clk);
        #1;
        check("reseed_lo", prng_load, 0);
        lat = 0;
        rand_stream();
        spawn_and_check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
